uart_rx_cfg: RTL and testbench

Parametrised UART receiver that succeeds the fixed 8N1 receiver in the `uart` block. It adds:
- configurable clock and baud rate, oversampling, data width, parity and stop bits;
- start-bit glitch rejection, framing/parity/break reporting, and an optional majority-vote sampler.

It sits between the board RX pin and the byte consumer, emitting one-cycle `valid_o` pulses with the received word and its error flags.

---
 rtl/uart_rx_cfg.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable baud, oversampling, data width, parity and stop bits.
// Optional feature macro: UART_RX_MAJORITY_EN selects a 2-of-3 majority-vote bit sampler.
module uart_rx_cfg #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 rx_i,
    output logic                 valid_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);

    localparam int TICK_RATE = BAUD_RATE * OVERSAMPLE;
    localparam int DIV       = (CLK_FREQ_HZ + TICK_RATE / 2) / TICK_RATE;
    localparam int DIV_W     = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int SAMP_W    = $clog2(OVERSAMPLE);
    localparam int BIT_W     = 4;
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC_IDX   = OVERSAMPLE / 2 + 1;
`else
    localparam int DEC_IDX   = OVERSAMPLE / 2;
`endif

    if (DIV < 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_rx_cfg: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rxs_q;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [SAMP_W-1:0]     samp_q, samp_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  stop1_q, stop1_d;
    logic                  valid_q, valid_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  brk_q, brk_d;

    logic tick, bit_end, sample_tick, bit_val, first_stop;

    assign tick        = (state_q != S_IDLE) && (div_q == DIV_W'(DIV - 1));
    assign bit_end     = tick && (samp_q == SAMP_W'(OVERSAMPLE - 1));
    assign sample_tick = tick && (samp_q == SAMP_W'(DEC_IDX));

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_q, vote_d;

    always_comb begin
        vote_d = vote_q;
        if (tick && samp_q == SAMP_W'(OVERSAMPLE / 2 - 1)) vote_d[0] = rxs_q;
        if (tick && samp_q == SAMP_W'(OVERSAMPLE / 2))     vote_d[1] = rxs_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) vote_q <= 2'b11;
        else           vote_q <= vote_d;
    end

    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs_q) | (vote_q[1] & rxs_q);
`else
    assign bit_val = rxs_q;
`endif

    // With two stop bits the break test looks at the first one, captured a period earlier.
    assign first_stop = (STOP_BITS == 2) ? stop1_q : bit_val;

    always_comb begin
        div_d  = div_q;
        samp_d = samp_q;
        if (state_q == S_IDLE) begin
            div_d  = '0;
            samp_d = '0;
        end else if (tick) begin
            div_d  = '0;
            samp_d = (samp_q == SAMP_W'(OVERSAMPLE - 1)) ? '0 : samp_q + SAMP_W'(1);
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        stop1_d = stop1_q;
        valid_d = 1'b0;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;

        case (state_q)
            S_IDLE: begin
                bit_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (sample_tick && bit_val) state_d = S_IDLE;
                else if (bit_end)           state_d = S_DATA;
            end
            S_DATA: begin
                if (sample_tick) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (sample_tick) par_d = bit_val;
                if (bit_end)     state_d = S_STOP;
            end
            S_STOP: begin
                if (sample_tick) begin
                    if (STOP_BITS == 2 && bit_q == '0) begin
                        stop1_d = bit_val;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        perr_d  = (PARITY != 0) && ((^{shift_q, par_q}) != (PARITY == 1));
                        ferr_d  = !bit_val || !first_stop;
                        brk_d   = (shift_q == '0) && (PARITY == 0 || !par_q) && !first_stop;
                        state_d = bit_val ? S_IDLE : S_WAIT_HIGH;
                    end
                end
                if (bit_end) bit_d = BIT_W'(1);
            end
            S_WAIT_HIGH: begin
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_ni) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= S_IDLE;
            div_q     <= '0;
            samp_q    <= '0;
            bit_q     <= '0;
            // NOTE: the shift register is reset too, so an aborted frame leaves nothing behind.
            shift_q   <= '0;
            par_q     <= 1'b0;
            stop1_q   <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            div_q     <= div_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            stop1_q   <= stop1_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
        end
    end

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign break_o      = brk_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed self-checking bench for uart_rx_cfg: three instances cover 8N1, even parity and 7-bit/2-stop.
module tb_uart_rx_cfg;

    localparam int BT      = 6400;   // 64 clocks per bit (DIV=4, OVERSAMPLE=16)
    localparam int BT_FAST = 6336;   // 1% fast
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 619;
`else
    localparam int LAT = 615;
`endif

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic reset_n = 1'b0;
    logic rx_a = 1'b1, rx_p = 1'b1, rx_b = 1'b1;

    logic       valid_a, perr_a, ferr_a, brk_a, busy_a;
    logic [7:0] data_a;
    logic       valid_p, perr_p, ferr_p, brk_p, busy_p;
    logic [7:0] data_p;
    logic       valid_b, perr_b, ferr_b, brk_b, busy_b;
    logic [6:0] data_b;

    uart_rx_cfg #(.CLK_FREQ_HZ(6_400_000), .BAUD_RATE(100_000)) dut_a (
        .clk_i(clk), .reset_ni(reset_n), .rx_i(rx_a), .valid_o(valid_a), .data_o(data_a),
        .parity_err_o(perr_a), .frame_err_o(ferr_a), .break_o(brk_a), .busy_o(busy_a));

    uart_rx_cfg #(.CLK_FREQ_HZ(6_400_000), .BAUD_RATE(100_000), .PARITY(2)) dut_p (
        .clk_i(clk), .reset_ni(reset_n), .rx_i(rx_p), .valid_o(valid_p), .data_o(data_p),
        .parity_err_o(perr_p), .frame_err_o(ferr_p), .break_o(brk_p), .busy_o(busy_p));

    uart_rx_cfg #(.CLK_FREQ_HZ(7_372_800), .BAUD_RATE(115_200), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
        .clk_i(clk), .reset_ni(reset_n), .rx_i(rx_b), .valid_o(valid_b), .data_o(data_b),
        .parity_err_o(perr_b), .frame_err_o(ferr_b), .break_o(brk_b), .busy_o(busy_b));

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } rec_t;

    rec_t q_a[$], q_p[$], q_b[$];
    int   n_checks = 0, n_err = 0, n_consec = 0, n_hold = 0;
    bit   hold_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records frames, flags back-to-back valid and outputs changing without valid.
    initial begin
        rec_t r;
        logic pv_a = 0, pv_p = 0, pv_b = 0;
        logic [11:0] la = 0, lp = 0, lb = 0;
        forever begin
            @(negedge clk);
            if (valid_a) begin r.data = {1'b0, data_a}; r.perr = perr_a; r.ferr = ferr_a; r.brk = brk_a; q_a.push_back(r); end
            if (valid_p) begin r.data = {1'b0, data_p}; r.perr = perr_p; r.ferr = ferr_p; r.brk = brk_p; q_p.push_back(r); end
            if (valid_b) begin r.data = {2'b0, data_b}; r.perr = perr_b; r.ferr = ferr_b; r.brk = brk_b; q_b.push_back(r); end
            if ((valid_a && pv_a) || (valid_p && pv_p) || (valid_b && pv_b)) n_consec++;
            if (hold_en && ((!valid_a && la != {1'b0, data_a, perr_a, ferr_a, brk_a}) ||
                            (!valid_p && lp != {1'b0, data_p, perr_p, ferr_p, brk_p}) ||
                            (!valid_b && lb != {2'b0, data_b, perr_b, ferr_b, brk_b}))) n_hold++;
            pv_a = valid_a; pv_p = valid_p; pv_b = valid_b;
            la = {1'b0, data_a, perr_a, ferr_a, brk_a};
            lp = {1'b0, data_p, perr_p, ferr_p, brk_p};
            lb = {2'b0, data_b, perr_b, ferr_b, brk_b};
        end
    end

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_p = v;
            default: rx_b = v;
        endcase
    endtask

    task automatic send_frame(input int sel, input logic [8:0] d, input int nbits, input bit has_par,
                              input logic par_bit, input int nstop, input logic stop_val, input int bt);
        set_line(sel, 1'b0); #(bt);
        for (int i = 0; i < nbits; i++) begin set_line(sel, d[i]); #(bt); end
        if (has_par) begin set_line(sel, par_bit); #(bt); end
        for (int i = 0; i < nstop; i++) begin set_line(sel, stop_val); #(bt); end
    endtask

    function automatic rec_t pick(input rec_t q[$], input int idx);
        return (idx < q.size()) ? q[idx] : '1;
    endfunction

    initial begin
        int   base, cnt;
        bit   found;
        rec_t r;

        repeat (5) @(negedge clk);
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_flags", {perr_a, ferr_a, brk_a}, 0);
        check("rst_busy", {busy_a, busy_p, busy_b}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        hold_en = 1'b1;

        // 15 back-to-back 8N1 frames at the nominal rate
        base = q_a.size();
        for (int b = 0; b < 15; b++) send_frame(0, 9'(b), 8, 0, 1'b0, 1, 1'b1, BT);
        #(2 * BT);
        check("seq_count", q_a.size() - base, 15);
        for (int b = 0; b < 15; b++) begin
            r = pick(q_a, base + b);
            check($sformatf("seq_data_%0d", b), r.data, b);
            check($sformatf("seq_flags_%0d", b), {r.perr, r.ferr, r.brk}, 0);
        end

        // Clock-aligned frame: valid_o latency from the start edge, and mid-frame busy
        base = q_a.size();
        @(negedge clk);
        fork
            send_frame(0, 9'h5A, 8, 0, 1'b0, 1, 1'b1, BT);
            begin
                cnt = 0; found = 0;
                while (!found && cnt < 2000) begin
                    @(negedge clk); cnt++;
                    if (cnt == 300) check("busy_mid_frame", busy_a, 1);
                    if (valid_a) found = 1;
                end
                check("valid_latency", cnt, LAT);
            end
        join
        #(BT);
        check("lat_data", pick(q_a, base).data, 9'h5A);

        // Even parity
        base = q_p.size();
        send_frame(1, 9'hA5, 8, 1, 1'b0, 1, 1'b1, BT);
        #(BT);
        send_frame(1, 9'hA5, 8, 1, 1'b1, 1, 1'b1, BT);
        #(2 * BT);
        check("par_count", q_p.size() - base, 2);
        r = pick(q_p, base);
        check("par_ok_data", r.data, 9'hA5);
        check("par_ok_flags", {r.perr, r.ferr, r.brk}, 3'b000);
        r = pick(q_p, base + 1);
        check("par_bad_data", r.data, 9'hA5);
        check("par_bad_flags", {r.perr, r.ferr, r.brk}, 3'b100);

        // Framing error with line held low, then a break
        base = q_a.size();
        send_frame(0, 9'h3C, 8, 0, 1'b0, 1, 1'b0, BT);
        #(2 * BT);
        check("wait_high_busy", busy_a, 1);
        rx_a = 1'b1;
        #(2 * BT);
        check("ferr_count", q_a.size() - base, 1);
        r = pick(q_a, base);
        check("ferr_data", r.data, 9'h3C);
        check("ferr_flags", {r.perr, r.ferr, r.brk}, 3'b010);
        base = q_a.size();
        send_frame(0, 9'h00, 8, 0, 1'b0, 1, 1'b0, BT);
        #(2 * BT);
        rx_a = 1'b1;
        #(2 * BT);
        check("brk_count", q_a.size() - base, 1);
        r = pick(q_a, base);
        check("brk_data", r.data, 0);
        check("brk_flags", {r.perr, r.ferr, r.brk}, 3'b011);

        // Short low pulse on the idle line is rejected
        base = q_a.size();
        rx_a = 1'b0;
        #(1000);
        check("glitch_busy_rise", busy_a, 1);
        #(920);
        rx_a = 1'b1;
        #(BT - 1920);
        check("glitch_busy_fall", busy_a, 0);
        #(BT);
        check("glitch_no_valid", q_a.size() - base, 0);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle high spike at the centre tick of data bit 3 is outvoted
        base = q_a.size();
        @(negedge clk);
        fork
            send_frame(0, 9'h00, 8, 0, 1'b0, 1, 1'b1, BT);
            begin repeat (292) @(negedge clk); rx_a = 1'b1; @(negedge clk); rx_a = 1'b0; end
        join
        #(BT);
        check("maj_count", q_a.size() - base, 1);
        check("maj_data", pick(q_a, base).data, 0);
`endif

        // 7 data bits, 2 stop bits, 1% fast, back to back
        base = q_b.size();
        send_frame(2, 9'h55, 7, 0, 1'b0, 2, 1'b1, BT_FAST);
        send_frame(2, 9'h2A, 7, 0, 1'b0, 2, 1'b1, BT_FAST);
        #(2 * BT);
        check("b7_count", q_b.size() - base, 2);
        r = pick(q_b, base);
        check("b7_data0", r.data, 9'h55);
        check("b7_flags0", {r.perr, r.ferr, r.brk}, 0);
        r = pick(q_b, base + 1);
        check("b7_data1", r.data, 9'h2A);
        check("b7_flags1", {r.perr, r.ferr, r.brk}, 0);

        // Reset pulse mid-data discards the frame
        base = q_a.size();
        fork
            send_frame(0, 9'hFF, 8, 0, 1'b0, 1, 1'b1, BT);
            begin
                #(22400);
                hold_en = 1'b0;
                @(negedge clk); reset_n = 1'b0;
                @(negedge clk); reset_n = 1'b1;
                check("rst_mid_busy", busy_a, 0);
                check("rst_mid_data", data_a, 0);
                repeat (2) @(negedge clk);
                hold_en = 1'b1;
            end
        join
        #(BT);
        send_frame(0, 9'h81, 8, 0, 1'b0, 1, 1'b1, BT);
        #(2 * BT);
        check("rst_mid_count", q_a.size() - base, 1);
        r = pick(q_a, base);
        check("rst_mid_after", r.data, 9'h81);
        check("rst_mid_flags", {r.perr, r.ferr, r.brk}, 0);

        check("no_consec_valid", n_consec, 0);
        check("outputs_hold", n_hold, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
